// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit: divider FSM states and the
// forwarding-mux select codes decoded by the execute-stage datapath.
package hazard_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
   localparam logic [1:0] FWD_WB  = 2'b01;  // operand from writeback stage
   localparam logic [1:0] FWD_MEM = 2'b10;  // operand from memory stage

   localparam int CNT_W = 8;

endpackage : hazard_unit_pkg

// File: rtl/hazard_unit_div_stall_fsm.sv
// Holds the front of the pipeline while a multi-cycle divide sits in
// execute. The divide is stalled for exactly DIV_LATENCY cycles, then a
// one-cycle DONE state releases the pipeline and flags the result.
module div_stall_fsm
   import hazard_unit_pkg::*;
#(
   parameter int DIV_LATENCY = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic divstart_i,
   output logic divstall_o,
   output logic div_busy_o,
   output logic div_done_o
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_LATENCY - 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State and countdown register; async reset returns straight to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: the cycle the divide is first seen counts as the first
   // stalled cycle, so BUSY only needs DIV_LATENCY-1 more.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (divstart_i) begin
               state_d = ST_BUSY;
               cnt_d   = CNT_INIT;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         // The finished divide is still visible in E here; ignore it.
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      divstall_o = ((state_q == ST_IDLE) && divstart_i) || (state_q == ST_BUSY);
      div_busy_o = (state_q != ST_IDLE);
      div_done_o = (state_q == ST_DONE);
   end

endmodule : div_stall_fsm

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline:
// execute/decode forwarding selects, load-use and branch stalls, and the
// divide hold sequenced by div_stall_fsm.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int DIV_LATENCY = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rsD,
   input  logic [REG_ADDR_W-1:0] rtD,
   input  logic [REG_ADDR_W-1:0] rsE,
   input  logic [REG_ADDR_W-1:0] rtE,
   input  logic [REG_ADDR_W-1:0] writeregE,
   input  logic [REG_ADDR_W-1:0] writeregM,
   input  logic [REG_ADDR_W-1:0] writeregW,
   input  logic                  regwriteE,
   input  logic                  regwriteM,
   input  logic                  regwriteW,
   input  logic                  memtoregE,
   input  logic                  memtoregM,
   input  logic                  branchD,
   input  logic                  divstartE,
   output logic [1:0]            forwardAE,
   output logic [1:0]            forwardBE,
   output logic                  forwardAD,
   output logic                  forwardBD,
   output logic                  stallF,
   output logic                  stallD,
   output logic                  stallE,
   output logic                  flushE,
   output logic                  div_busy,
   output logic                  div_done
);

   logic [REG_ADDR_W-1:0] src_e [2];
   logic [REG_ADDR_W-1:0] src_d [2];
   logic [1:0]            fwd_e [2];
   logic                  fwd_d [2];
   logic                  lwstall;
   logic                  branchstall;
   logic                  divstall;

   assign src_e[0] = rsE;
   assign src_e[1] = rtE;
   assign src_d[0] = rsD;
   assign src_d[1] = rtD;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         // Execute operand select; the younger result in M wins over W, r0 never forwards.
         always_comb begin
            fwd_e[gi] = FWD_RF;
            if ((src_e[gi] != '0) && regwriteM && (writeregM == src_e[gi])) begin
               fwd_e[gi] = FWD_MEM;
            end else if ((src_e[gi] != '0) && regwriteW && (writeregW == src_e[gi])) begin
               fwd_e[gi] = FWD_WB;
            end
         end

         // Branch comparator in decode can only take the ALU result sitting in M.
         always_comb begin
            fwd_d[gi] = (src_d[gi] != '0) && regwriteM && (writeregM == src_d[gi]);
         end
      end
   endgenerate

   assign forwardAE = fwd_e[0];
   assign forwardBE = fwd_e[1];
   assign forwardAD = fwd_d[0];
   assign forwardBD = fwd_d[1];

   // Load-use and branch-operand-not-ready detection.
   always_comb begin
      lwstall     = memtoregE && ((rtE == rsD) || (rtE == rtD));
      branchstall = branchD &&
                    ((regwriteE && (writeregE != '0) &&
                      ((writeregE == rsD) || (writeregE == rtD))) ||
                     (memtoregM && (writeregM != '0) &&
                      ((writeregM == rsD) || (writeregM == rtD))));
   end

   div_stall_fsm #(
      .DIV_LATENCY(DIV_LATENCY)
   ) u_div_stall_fsm (
      .clk        (clk),
      .rst        (rst),
      .divstart_i (divstartE),
      .divstall_o (divstall),
      .div_busy_o (div_busy),
      .div_done_o (div_done)
   );

   // A divide held in E freezes ID/EX rather than bubbling it; the
   // load/branch condition is simply re-evaluated once the divide releases.
   always_comb begin
      stallF = lwstall || branchstall || divstall;
      stallD = lwstall || branchstall || divstall;
      stallE = divstall;
      flushE = (lwstall || branchstall) && !divstall;
   end

endmodule : hazard_unit

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit. Stimulus pushes the hand-computed
// expected outputs into a scoreboard queue; a monitor pops and compares at
// the falling edge of each cycle that has a pending expectation.
module tb_hazard_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
   logic       branchD, divstartE;
   logic [1:0] forwardAE, forwardBE;
   logic       forwardAD, forwardBD, stallF, stallD, stallE, flushE;
   logic       div_busy, div_done;

   int total = 0;
   int bad   = 0;

   logic [12:0] exp_q  [$];
   string       name_q [$];

   always #5 clk = ~clk;

   hazard_unit #(.REG_ADDR_W(5), .DIV_LATENCY(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .rsD       (rsD),
      .rtD       (rtD),
      .rsE       (rsE),
      .rtE       (rtE),
      .writeregE (writeregE),
      .writeregM (writeregM),
      .writeregW (writeregW),
      .regwriteE (regwriteE),
      .regwriteM (regwriteM),
      .regwriteW (regwriteW),
      .memtoregE (memtoregE),
      .memtoregM (memtoregM),
      .branchD   (branchD),
      .divstartE (divstartE),
      .forwardAE (forwardAE),
      .forwardBE (forwardBE),
      .forwardAD (forwardAD),
      .forwardBD (forwardBD),
      .stallF    (stallF),
      .stallD    (stallD),
      .stallE    (stallE),
      .flushE    (flushE),
      .div_busy  (div_busy),
      .div_done  (div_done)
   );

   // Packs {fAE, fBE, fAD, fBD, stallF, stallD, stallE, flushE, busy, done}
   function automatic logic [12:0] mk(input logic [1:0] fae, input logic [1:0] fbe,
                                      input logic fad, input logic fbd,
                                      input logic stl, input logic stle,
                                      input logic flush, input logic busy,
                                      input logic done);
      return {1'b0, fae, fbe, fad, fbd, stl, stl, stle, flush, busy, done};
   endfunction

   // Monitor: compare once per cycle that carries an expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [12:0] e, a;
         string       n;
         e = exp_q.pop_front();
         n = name_q.pop_front();
         a = {1'b0, forwardAE, forwardBE, forwardAD, forwardBD,
              stallF, stallD, stallE, flushE, div_busy, div_done};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL %s got=%b want=%b (fAE fBE fAD fBD sF sD sE fl busy done)",
                     n, a, e);
         end else begin
            $display("chk %-12s ok  %b", n, a);
         end
      end
   end

   // Queue an expectation for the current cycle, then move to the next one.
   task automatic step(input string n, input logic [12:0] e);
      exp_q.push_back(e);
      name_q.push_back(n);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rsD = 0; rtD = 0; rsE = 0; rtE = 0;
      writeregE = 0; writeregM = 0; writeregW = 0;
      regwriteE = 0; regwriteM = 0; regwriteW = 0;
      memtoregE = 0; memtoregM = 0; branchD = 0; divstartE = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired total=%0d", total);
      $fatal(1, "timeout");
   end

   initial begin
      clear_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      step("reset", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;

      // Execute forwarding priority
      regwriteM = 1; writeregM = 5; regwriteW = 1; writeregW = 5; rsE = 5;
      step("fAE_mem", mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      regwriteM = 0;
      step("fAE_wb", mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      rsE = 0; writeregM = 0; writeregW = 0;
      step("fAE_r0", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      writeregW = 7; rtE = 7;
      step("fBE_wb", mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0));
      regwriteM = 1; writeregM = 7;
      step("fBE_mem", mk(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0));
      clear_inputs();

      // Load-use
      memtoregE = 1; rtE = 8; rsD = 8;
      step("lw_rs", mk(2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0));
      rsD = 0; rtD = 8;
      step("lw_rt", mk(2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0));
      rtE = 0; rtD = 0;
      step("lw_r0", mk(2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0));
      memtoregE = 0; rtE = 8; rsD = 8;
      step("lw_clear", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      clear_inputs();

      // Branch hazards
      branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3;
      step("br_aluE", mk(2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0));
      regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 3;
      step("br_fwdM", mk(2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 0));
      memtoregM = 1;
      step("br_loadM", mk(2'b00, 2'b00, 0, 1, 1, 0, 1, 0, 0));
      clear_inputs();

      // Divide held high: stall cycles 0..7, done at 8, restart at 9
      divstartE = 1;
      for (int i = 0; i < 10; i++) begin
         string n;
         n = $sformatf("div_c%0d", i);
         if (i == 0 || i == 9)
            step(n, mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0));
         else if (i == 8)
            step(n, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1));
         else
            step(n, mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0));
      end

      // Second divide is BUSY (cnt 7..1); add a load-use on top
      memtoregE = 1; rtE = 4; rsD = 4;
      for (int i = 0; i < 7; i++) begin
         step($sformatf("divlw_b%0d", i), mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0));
      end
      step("divlw_done", mk(2'b00, 2'b00, 0, 0, 1, 0, 1, 1, 1));
      divstartE = 0;
      step("divlw_after", mk(2'b00, 2'b00, 0, 0, 1, 0, 1, 0, 0));
      clear_inputs();
      step("idle", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

      // Reset while BUSY with cnt=4
      divstartE = 1;
      step("rst_start", mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0));
      for (int i = 0; i < 3; i++) begin
         step($sformatf("rst_b%0d", i), mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0));
      end
      rst = 1; divstartE = 0;
      step("rst_mid", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));
      rst = 0; divstartE = 1;
      for (int i = 0; i < 9; i++) begin
         string n;
         n = $sformatf("post_c%0d", i);
         if (i == 0)
            step(n, mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0));
         else if (i == 8)
            step(n, mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1));
         else
            step(n, mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0));
      end
      divstartE = 0;
      step("final", mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0));

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_hazard_unit

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Hazard detection and forwarding control for the 5-stage pipelined MIPS core. It generates the 2-bit select codes consumed by the execute-stage 3-input forwarding muxes, and the 1-bit decode-stage branch-compare forwarding selects. It also produces stall/flush controls for load-use and branch hazards. It contains a small FSM that holds the front of the pipeline while a multi-cycle divide occupies the execute stage.

Parameters:
REG_ADDR_W, 5, register-specifier width
DIV_LATENCY, 8, total cycles a divide occupies execute (legal range 2..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rsD, rtD  in  REG_ADDR_W  decode-stage source registers
rsE, rtE  in  REG_ADDR_W  execute-stage source registers
writeregE, writeregM, writeregW  in  REG_ADDR_W  destination register per stage
regwriteE, regwriteM, regwriteW  in  1  register-write enable per stage
memtoregE, memtoregM  in  1  load instruction in E / M
branchD  in  1  branch in decode
divstartE  in  1  divide instruction present in execute
forwardAE, forwardBE  out  2  execute forwarding mux selects
forwardAD, forwardBD  out  1  decode branch-compare forwarding selects
stallF, stallD, stallE  out  1  hold PC, IF/ID, ID/EX registers
flushE  out  1  clear ID/EX register (bubble)
div_busy  out  1  divider FSM not IDLE
div_done  out  1  one-cycle pulse: divide result valid, pipeline released

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. On rst: state=IDLE, cnt=0, div_busy=0, div_done=0. Combinational outputs follow the inputs with the FSM in IDLE.
- forwardAE encoding:
  - 2'b10 when rsE!=0 && regwriteM && writeregM==rsE (M has priority).
  - Otherwise 2'b01 when rsE!=0 && regwriteW && writeregW==rsE.
  - Otherwise 2'b00 (register file).
  - 2'b11 is never driven.
- forwardBE: identical rule using rtE.
- forwardAD = rsD!=0 && regwriteM && writeregM==rsD. forwardBD: same rule with rtD.
- lwstall = memtoregE && ((rtE==rsD) || (rtE==rtD)).
- branchstall = branchD && ((regwriteE && writeregE!=0 && (writeregE==rsD || writeregE==rtD)) || (memtoregM && writeregM!=0 && (writeregM==rsD || writeregM==rtD))).
- divstall = (state==IDLE && divstartE) || state==BUSY.
- stallF = stallD = lwstall || branchstall || divstall.
- stallE = divstall.
- flushE = (lwstall || branchstall) && !divstall. While the divide is held in E, ID/EX is frozen, not flushed.
- FSM states IDLE, BUSY, DONE; 8-bit cnt.
  - IDLE: divstartE -> BUSY, cnt<=DIV_LATENCY-1.
  - BUSY: cnt<=cnt-1; when cnt==1 -> DONE.
  - DONE: div_done=1, stall released, divstartE ignored (the same divide is still visible in E this cycle); -> IDLE.
- Latency: a divide entering E at cycle t asserts stallE for cycles t..t+DIV_LATENCY-1 (exactly DIV_LATENCY cycles). div_done is high at t+DIV_LATENCY. A back-to-back divide can start at t+DIV_LATENCY+1 at the earliest.
- div_busy = state!=IDLE.
- Simultaneous load-use and divide: divide dominates. stalls are held and flushE=0. The load-use condition is re-evaluated after release.
- rst asserted mid-BUSY: FSM returns to IDLE immediately and stalls drop in the same cycle.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and forwarding select constants (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10). These are the codes the datapath forwarding muxes decode.
- One natural sub-module: div_stall_fsm, containing the state, cnt, divstall, div_busy and div_done. Forwarding and load/branch hazard logic stay combinational in the top.

Test Plan:
- regwriteM=1, writeregM=5, regwriteW=1, writeregW=5, rsE=5 -> forwardAE=2'b10. Then regwriteM=0 -> forwardAE=2'b01. Then rsE=0 with writeregM=writeregW=0 -> forwardAE=2'b00.
- memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=1, flushE=1, stallE=0. The next cycle, with memtoregE=0, all four deasserted.
- branchD=1, regwriteE=1, writeregE=3, rtD=3 -> stallD=1, flushE=1. With the writer in M instead (regwriteM=1, writeregM=3, memtoregM=0) -> no stall, forwardBD=1.
- DIV_LATENCY=8, divstartE held high from t=0 -> stallE=1 for cycles 0..7, div_busy=1 for 1..8, div_done=1 only at cycle 8, no restart at cycle 8. divstartE still high at cycle 9 -> new divide starts.
- Divide in E plus memtoregE=1, rtE=rsD during BUSY -> flushE=0, stallF/D/E=1. After DONE, lwstall alone produces flushE=1.
- rst pulsed at BUSY cnt=4 -> div_busy=0 and stallE=0 within the same cycle. A subsequent divstartE produces a full DIV_LATENCY-cycle stall.
